instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//   Upstream write stage of the per-tile instruction memory.
//   - Accepts a load packet (header, N instruction words, XOR checksum) on a valid/ready stream from the NoC adaptor.
//   - Writes the words into the single-port instruction RAM through its Avalon-MM slave write port.
//   - Reports completion or error to the tile controller.
// PARAMETERS
//   ADDR_W       10     word-address width of the instruction RAM (depth 2**ADDR_W)
//   DATA_W       32     instruction word width; byteenable width is DATA_W/8
//   LOAD_OPCODE  4'hA   header[31:28] value identifying a load packet
// PORTS
//   clk             in   1       single clock; all logic rising-edge
//   reset           in   1       asynchronous, active-high reset
//   in_valid        in   1       stream word valid
//   in_data         in   DATA_W  stream word
//   in_ready        out  1       loader accepts in_data this cycle
//   mem_hold        in   1       RAM busy (reset_req/freeze upstream); stalls loader
//   mem_chipselect  out  1       RAM slave chipselect
//   mem_write       out  1       RAM write strobe
//   mem_address     out  ADDR_W  RAM word address
//   mem_byteenable  out  DATA_W/8 always all-ones while mem_write=1, else 0
//   mem_writedata   out  DATA_W  RAM write data
//   mem_clken       out  1       RAM clock enable = ~mem_hold
//   busy            out  1       high in any state other than IDLE
//   load_done       out  1       one-cycle pulse: packet loaded, checksum good
//   load_err        out  1       one-cycle pulse: bad header or checksum mismatch
// BEHAVIOUR
//   Reset
//     - Every output is 0 except mem_clken (=~mem_hold). FSM=IDLE; counters and checksum are 0.
//     - Assertion mid-packet aborts immediately; a partially written RAM image is left as-is.
//   Handshake
//     - A word transfers when in_valid & in_ready.
//     - in_ready = ~mem_hold & state in {IDLE, LOAD, CHECK}.
//     - in_data is ignored when in_valid=0.
//   Header word fields
//     - [31:28] opcode
//     - [25:16] base word address
//     - [10:0]  count
//     - Valid only when opcode==LOAD_OPCODE and 1 <= count <= 2**ADDR_W.
//   FSM (IDLE, LOAD, CHECK, DONE)
//     - IDLE: header accepted & valid -> LOAD; addr_ptr<=base, remaining<=count, csum<=0.
//       Header accepted & invalid -> load_err pulse next cycle; stay IDLE; word dropped.
//     - LOAD: each accepted word -> csum^=word, addr_ptr<=addr_ptr+1 (mod 2**ADDR_W), remaining-=1.
//       remaining reaches 0 -> CHECK.
//     - CHECK: accepted word is compared with csum.
//       Equal -> DONE with load_done pulse. Unequal -> DONE with load_err pulse. Never both.
//     - DONE: one cycle, in_ready=0, -> IDLE unconditionally.
//   Write path (registered, latency 1)
//     - A word accepted in LOAD in cycle t gives, in cycle t+1:
//       mem_chipselect=mem_write=1, mem_address=pointer value at t, mem_writedata=word, mem_byteenable=all-ones.
//     - No acceptance in t gives mem_write=mem_chipselect=0 in t+1. Sustained throughput is 1 word/cycle.
//   Stall
//     - mem_hold=1 forces in_ready=0, so no new write is generated.
//     - A write already presented when mem_hold rises is held stable (strobe and data unchanged) until mem_hold=0.
//     - No write is lost or duplicated.
//   Wrap
//     - base+count beyond 2**ADDR_W-1 wraps to address 0. count=2**ADDR_W overwrites the whole RAM exactly once.
//   Pulse timing
//     - load_done/load_err assert in the cycle the FSM is in DONE, or the cycle after a rejected header.
//     - The last RAM write (cycle after final data word) always precedes or coincides with load_done.
// TESTING
//   1. Header A0050003, data 11,22,33, trailer 00 (11^22^33) -> writes @5=11,@6=22,@7=33 on consecutive cycles; load_done=1 once; busy back to 0.
//   2. Header with opcode 4'h3 -> no mem_write; load_err one cycle; next valid packet loads normally.
//   3. Base 0x3FE, count 4 -> addresses 3FE,3FF,000,001 written in that order.
//   4. Wrong trailer on 2-word packet -> both words written; load_err=1, load_done=0.
//   5. mem_hold pulsed 3 cycles mid-LOAD -> in_ready low those cycles; write sequence unchanged, no gaps lost or repeats.
//   6. reset asserted after 2 of 5 data words -> outputs 0 same cycle; FSM IDLE; a fresh full packet then loads correctly.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a load packet (header, N instruction words, XOR checksum)
// on a valid/ready stream and writes the words into the single-port instruction RAM through
// its Avalon-MM slave write port, then reports completion or error with a one-cycle pulse.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_i          asynchronous active-high reset
//   in_valid_i       stream word valid
//   in_data_i        stream word
//   in_ready_o       loader accepts in_data_i this cycle
//   mem_hold_i       RAM busy; stalls the loader and freezes a pending write
//   mem_chipselect_o RAM chipselect
//   mem_write_o      RAM write strobe
//   mem_address_o    RAM word address
//   mem_byteenable_o all-ones while mem_write_o is high, else zero
//   mem_writedata_o  RAM write data
//   mem_clken_o      RAM clock enable (~mem_hold_i)
//   busy_o           FSM not idle
//   load_done_o      pulse: packet loaded and checksum matched
//   load_err_o       pulse: bad header or checksum mismatch
module instr_mem_loader #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter logic [3:0]  LOAD_OPCODE = 4'hA
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  input  logic [DATA_W-1:0]   in_data_i,
  output logic                in_ready_o,
  input  logic                mem_hold_i,
  output logic                mem_chipselect_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_address_o,
  output logic [DATA_W/8-1:0] mem_byteenable_o,
  output logic [DATA_W-1:0]   mem_writedata_o,
  output logic                mem_clken_o,
  output logic                busy_o,
  output logic                load_done_o,
  output logic                load_err_o
);

  localparam int unsigned CntW     = ADDR_W + 1;
  localparam int unsigned BeW      = DATA_W / 8;
  localparam int unsigned MaxWords = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [3:0]          hdr_opcode;
  logic [ADDR_W-1:0]   hdr_base;
  logic [10:0]         hdr_count;
  logic                hdr_ok;

  // Gated by reset so every stream/RAM output reads 0 while reset is held.
  assign in_ready_o = ~reset_i & ~mem_hold_i & (state_q != StDone);
  assign accept     = in_valid_i & in_ready_o;

  assign hdr_opcode = in_data_i[31:28];
  assign hdr_base   = in_data_i[16 +: ADDR_W];
  assign hdr_count  = in_data_i[10:0];
  assign hdr_ok     = (hdr_opcode == LOAD_OPCODE) && (hdr_count != 11'd0) &&
                      (32'(hdr_count) <= MaxWords);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // A write presented while the RAM is held stays on the bus until the hold drops.
    wr_d    = mem_hold_i ? wr_q : 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_ok) begin
            state_d = StLoad;
            addr_d  = hdr_base;
            rem_d   = CntW'(hdr_count);
            csum_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          csum_d  = csum_q ^ in_data_i;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - CntW'(1);
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data_i;
          if (rem_q == CntW'(1)) state_d = StCheck;
        end
      end
      StCheck: begin
        if (accept) begin
          state_d = StDone;
          if (in_data_i == csum_q) done_d = 1'b1;
          else                     err_d  = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_chipselect_o = wr_q;
  assign mem_write_o      = wr_q;
  assign mem_address_o    = waddr_q;
  assign mem_writedata_o  = wdata_q;
  assign mem_byteenable_o = {BeW{wr_q}};
  assign mem_clken_o      = ~mem_hold_i;
  assign busy_o           = (state_q != StIdle);
  assign load_done_o      = done_q;
  assign load_err_o       = err_q;

endmodule
